// File: rtl/pwm_duty_meter_if.sv
// Result channel of the PWM duty meter: valid/ready handshake carrying one measurement.
interface pwm_duty_meter_if #(
   parameter int CNT_W = 16
);
   logic             meas_valid;
   logic             meas_ready;
   logic [3:0]       duty_tenths;
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] high_cnt;
   logic             timeout;

   modport master (
      output meas_valid, duty_tenths, period_cnt, high_cnt, timeout,
      input  meas_ready
   );

   modport slave (
      input  meas_valid, duty_tenths, period_cnt, high_cnt, timeout,
      output meas_ready
   );
endinterface

// File: rtl/pwm_duty_meter.sv
// Measures one PWM period and its high time in clk cycles, then divides to duty tenths (<=11 cycles).
// The result is held on a valid/ready channel until accepted; input edges are ignored while the result waits.
module pwm_duty_meter #(
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pwm_in,
   output logic                 busy,
   pwm_duty_meter_if.master     m
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEASURE,
      S_DIVIDE,
      S_VALID
   } state_t;

   state_t           state;
   logic             s1, sync, hist;
   logic             rise;
   logic [CNT_W-1:0] cnt, hcnt;
   logic [CNT_W+3:0] rem;
   logic [3:0]       q;
   logic [CNT_W+3:0] hcnt_x10;
   logic [CNT_W+3:0] per_ext;

   assign rise     = sync & ~hist;
   assign hcnt_x10 = {1'b0, hcnt, 3'b000} + {3'b000, hcnt, 1'b0};
   assign per_ext  = {4'b0000, m.period_cnt};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1            <= 1'b0;
         sync          <= 1'b0;
         hist          <= 1'b0;
         state         <= S_IDLE;
         cnt           <= '0;
         hcnt          <= '0;
         rem           <= '0;
         q             <= '0;
         busy          <= 1'b0;
         m.meas_valid  <= 1'b0;
         m.duty_tenths <= '0;
         m.period_cnt  <= '0;
         m.high_cnt    <= '0;
         m.timeout     <= 1'b0;
      end else begin
         s1   <= pwm_in;
         sync <= s1;
         hist <= sync;

         case (state)
            S_IDLE: begin
               if (rise) begin
                  cnt   <= CNT_W'(1);
                  hcnt  <= CNT_W'(1);
                  state <= S_MEASURE;
               end else if (cnt == CNT_LAST) begin
                  m.timeout     <= 1'b1;
                  m.period_cnt  <= '0;
                  m.high_cnt    <= '0;
                  m.duty_tenths <= sync ? 4'd10 : 4'd0;
                  m.meas_valid  <= 1'b1;
                  busy          <= 1'b1;
                  state         <= S_VALID;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_MEASURE: begin
               if (rise) begin
                  m.period_cnt <= cnt;
                  m.high_cnt   <= hcnt;
                  rem          <= hcnt_x10;
                  q            <= '0;
                  busy         <= 1'b1;
                  state        <= S_DIVIDE;
               end else if (cnt == CNT_LAST) begin
                  // Stuck line: the level it is stuck at decides 0% or 100%.
                  m.timeout     <= 1'b1;
                  m.period_cnt  <= '0;
                  m.high_cnt    <= '0;
                  m.duty_tenths <= sync ? 4'd10 : 4'd0;
                  m.meas_valid  <= 1'b1;
                  busy          <= 1'b1;
                  state         <= S_VALID;
               end else begin
                  cnt  <= cnt + CNT_W'(1);
                  hcnt <= hcnt + {{(CNT_W-1){1'b0}}, sync};
               end
            end

            S_DIVIDE: begin
               // high < period, so the quotient never exceeds 9.
               if (rem >= per_ext) begin
                  rem <= rem - per_ext;
                  q   <= q + 4'd1;
               end else begin
                  m.duty_tenths <= q;
                  m.meas_valid  <= 1'b1;
                  state         <= S_VALID;
               end
            end

            S_VALID: begin
               if (m.meas_ready) begin
                  m.meas_valid <= 1'b0;
                  m.timeout    <= 1'b0;
                  cnt          <= '0;
                  busy         <= 1'b0;
                  state        <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: timeouts, duty sweep, floor rounding, backpressure and mid-run resets.
module tb_pwm_duty_meter;

   logic clk;
   logic rst_n;
   logic pwm_in;
   logic busy;

   int vectors     = 0;
   int miscompares = 0;
   int per_v = 10;
   int hi_v  = 0;
   int ph    = 0;
   int n;
   int guard;

   pwm_duty_meter_if #(.CNT_W(16)) mi ();

   pwm_duty_meter #(
      .CNT_W          (16),
      .TIMEOUT_CYCLES (20)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_in (pwm_in),
      .busy   (busy),
      .m      (mi)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: wait for the falling edge, then drive the next PWM phase.
   task automatic tick();
      @(negedge clk);
      pwm_in = (ph < hi_v);
      ph = (ph + 1) % per_v;
   endtask

   task automatic set_pwm(input int p, input int h);
      per_v = p;
      hi_v  = h;
      ph    = 0;
   endtask

   task automatic wait_result(input string tag, output int cycles);
      bit found;
      found  = 1'b0;
      cycles = 0;
      while (!found && cycles < 100) begin
         tick();
         cycles++;
         found = mi.meas_valid;
      end
      chk({tag, "_seen"}, 32'(found), 32'd1);
   endtask

   task automatic chk_result(input string tag, input int p, input int h, input int d, input int to);
      chk({tag, "_period"},  mi.period_cnt,  p);
      chk({tag, "_high"},    mi.high_cnt,    h);
      chk({tag, "_duty"},    mi.duty_tenths, d);
      chk({tag, "_timeout"}, mi.timeout,     to);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, mi.meas_valid, 0);
      chk({tag, "_busy"},  busy,          0);
      chk_result(tag, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      pwm_in        = 1'b0;
      mi.meas_ready = 1'b1;
      set_pwm(10, 0);
      repeat (3) tick();
      chk_zero("reset");
      rst_n = 1'b1;

      // Stuck low from reset: result lands exactly 20 edges later.
      wait_result("to_low", n);
      chk("to_low_latency", n, 20);
      chk_result("to_low", 0, 0, 0, 1);
      chk("to_low_busy", busy, 1);
      set_pwm(10, 10);
      tick();
      chk("to_low_pulse", mi.meas_valid, 0);

      wait_result("to_high", n);
      chk_result("to_high", 0, 0, 10, 1);
      tick();
      chk("to_high_pulse", mi.meas_valid, 0);

      // 50% duty; consecutive results are 20 cycles apart.
      set_pwm(10, 5);
      wait_result("d50_skip", n);
      wait_result("d50", n);
      chk_result("d50", 10, 5, 5, 0);
      tick();
      chk("d50_pulse", mi.meas_valid, 0);
      wait_result("d50_next", n);
      chk("d50_gap", n + 1, 20);
      chk_result("d50_next", 10, 5, 5, 0);

      for (int d = 1; d <= 9; d++) begin
         set_pwm(10, d);
         wait_result($sformatf("sweep%0d_skip", d), n);
         wait_result($sformatf("sweep%0d", d), n);
         chk_result($sformatf("sweep%0d", d), 10, d, d, 0);
      end

      set_pwm(7, 2);
      wait_result("p7_skip", n);
      wait_result("p7", n);
      chk_result("p7", 7, 2, 2, 0);

      // Backpressure: result must sit untouched while the line keeps toggling.
      set_pwm(10, 3);
      wait_result("bp_skip", n);
      tick();
      mi.meas_ready = 1'b0;
      wait_result("bp", n);
      chk_result("bp", 10, 3, 3, 0);
      repeat (30) tick();
      chk("bp_hold_valid", mi.meas_valid, 1);
      chk("bp_hold_busy", busy, 1);
      chk_result("bp_hold", 10, 3, 3, 0);
      mi.meas_ready = 1'b1;
      tick();
      chk("bp_drop_valid", mi.meas_valid, 0);
      chk_result("bp_after", 10, 3, 3, 0);
      wait_result("bp_fresh", n);
      chk_result("bp_fresh", 10, 3, 3, 0);

      // Reset while dividing (pwm already low when reset releases).
      set_pwm(10, 2);
      wait_result("rdiv_skip", n);
      tick();
      guard = 0;
      while (!busy && guard < 40) begin
         tick();
         guard++;
      end
      chk("rdiv_reach_divide", busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_zero("rdiv");
      wait_result("rdiv_new", n);
      chk("rdiv_full_period", n >= 10, 1);
      chk_result("rdiv_new", 10, 2, 2, 0);

      // Reset in the low phase of a running measurement.
      set_pwm(10, 4);
      wait_result("rmeas_skip", n);
      tick();
      guard = 0;
      while (ph != 1 && guard < 20) begin
         tick();
         guard++;
      end
      while (ph != 8 && guard < 40) begin
         tick();
         guard++;
      end
      chk("rmeas_in_measure", busy, 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_zero("rmeas");
      wait_result("rmeas_new", n);
      chk("rmeas_full_period", n >= 10, 1);
      chk_result("rmeas_new", 10, 4, 4, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
